// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register for the ARM-subset core.
// Captures decoded control, operands, shifter operand and immediate fields
// once per cycle.
// Per-edge priority: rst > flush > freeze > load.
// Optional feature macro: ID_EXE_FORWARDING_EN. When it is defined,
// src1_out and src2_out are registered for the forwarding unit; otherwise
// they are tied to zero and no flops are built for them.
module id_exe_reg #(
  parameter int WORD_WIDTH            = 32,
  parameter int SHIFTER_OPERAND_WIDTH = 12,
  parameter int REG_ADDR_WIDTH        = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             freeze,
  input  logic                             flush,
  input  logic                             wb_en_in,
  input  logic                             mem_r_en_in,
  input  logic                             mem_w_en_in,
  input  logic                             b_in,
  input  logic                             s_in,
  input  logic [3:0]                       exe_cmd_in,
  input  logic                             imm_in,
  input  logic [WORD_WIDTH-1:0]            pc_in,
  input  logic [WORD_WIDTH-1:0]            val_rn_in,
  input  logic [WORD_WIDTH-1:0]            val_rm_in,
  input  logic [SHIFTER_OPERAND_WIDTH-1:0] shift_operand_in,
  input  logic [23:0]                      signed_imm24_in,
  input  logic [REG_ADDR_WIDTH-1:0]        dest_in,
  input  logic [REG_ADDR_WIDTH-1:0]        src1_in,
  input  logic [REG_ADDR_WIDTH-1:0]        src2_in,
  input  logic [3:0]                       status_in,
  input  logic                             valid_in,
  output logic                             wb_en_out,
  output logic                             mem_r_en_out,
  output logic                             mem_w_en_out,
  output logic                             b_out,
  output logic                             s_out,
  output logic [3:0]                       exe_cmd_out,
  output logic                             imm_out,
  output logic [WORD_WIDTH-1:0]            pc_out,
  output logic [WORD_WIDTH-1:0]            val_rn_out,
  output logic [WORD_WIDTH-1:0]            val_rm_out,
  output logic [SHIFTER_OPERAND_WIDTH-1:0] shift_operand_out,
  output logic [23:0]                      signed_imm24_out,
  output logic [REG_ADDR_WIDTH-1:0]        dest_out,
  output logic [REG_ADDR_WIDTH-1:0]        src1_out,
  output logic [REG_ADDR_WIDTH-1:0]        src2_out,
  output logic [3:0]                       status_out,
  output logic                             valid_out
);

  // Main pipeline register: reset/flush clear everything (a bubble is identical
  // to reset), freeze holds, load gates control bits with valid_in so an invalid
  // slot can never write back, store or branch.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wb_en_out         <= 1'b0;
      mem_r_en_out      <= 1'b0;
      mem_w_en_out      <= 1'b0;
      b_out             <= 1'b0;
      s_out             <= 1'b0;
      exe_cmd_out       <= 4'b0000;
      imm_out           <= 1'b0;
      pc_out            <= '0;
      val_rn_out        <= '0;
      val_rm_out        <= '0;
      shift_operand_out <= '0;
      signed_imm24_out  <= 24'd0;
      dest_out          <= '0;
      status_out        <= 4'b0000;
      valid_out         <= 1'b0;
    end else if (freeze) begin
      wb_en_out         <= wb_en_out;
      mem_r_en_out      <= mem_r_en_out;
      mem_w_en_out      <= mem_w_en_out;
      b_out             <= b_out;
      s_out             <= s_out;
      exe_cmd_out       <= exe_cmd_out;
      imm_out           <= imm_out;
      pc_out            <= pc_out;
      val_rn_out        <= val_rn_out;
      val_rm_out        <= val_rm_out;
      shift_operand_out <= shift_operand_out;
      signed_imm24_out  <= signed_imm24_out;
      dest_out          <= dest_out;
      status_out        <= status_out;
      valid_out         <= valid_out;
    end else begin
      wb_en_out         <= wb_en_in & valid_in;
      mem_r_en_out      <= mem_r_en_in & valid_in;
      mem_w_en_out      <= mem_w_en_in & valid_in;
      b_out             <= b_in & valid_in;
      s_out             <= s_in & valid_in;
      exe_cmd_out       <= valid_in ? exe_cmd_in : 4'b0000;
      imm_out           <= imm_in & valid_in;
      pc_out            <= pc_in;
      val_rn_out        <= val_rn_in;
      val_rm_out        <= val_rm_in;
      shift_operand_out <= shift_operand_in;
      signed_imm24_out  <= signed_imm24_in;
      dest_out          <= dest_in;
      status_out        <= status_in;
      valid_out         <= valid_in;
    end
  end

`ifdef ID_EXE_FORWARDING_EN
  // Source register numbers for the forwarding unit, same rst/flush/freeze rules.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      src1_out <= '0;
      src2_out <= '0;
    end else if (freeze) begin
      src1_out <= src1_out;
      src2_out <= src2_out;
    end else begin
      src1_out <= src1_in;
      src2_out <= src2_in;
    end
  end
`else
  // Forwarding disabled: no source-number flops; inputs intentionally unused.
  assign src1_out = '0;
  assign src2_out = '0;
`endif

endmodule
